// File: rtl/inv_sub_bytes_pipe.sv
// Elastic LANES-wide AES InvSubBytes stage with 1 or 2 register stages and a 16-bit beat counter.
// Define SBOX_FWD_EN to also build the forward SubBytes table, selected per beat by in_mode.
module inv_sub_bytes_pipe #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_mode,
  output logic [15:0]          beat_cnt
);

  localparam int unsigned W = 8 * LANES;

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("inv_sub_bytes_pipe: LANES must be in 1..16");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("inv_sub_bytes_pipe: LATENCY must be 1 or 2");
  end

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [W-1:0] inv_lanes(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      r[8*i +: 8] = InvSbox[d[8*i +: 8]];
    end
    return r;
  endfunction

`ifdef SBOX_FWD_EN
  localparam logic [7:0] FwdSbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [W-1:0] fwd_lanes(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      r[8*i +: 8] = FwdSbox[d[8*i +: 8]];
    end
    return r;
  endfunction
`endif

  logic           w_in_mode;
  logic           w_in_ready;
  logic [W-1:0]   w_lookup_src;
  logic           w_lookup_mode;
  logic [W-1:0]   w_inv;
  logic [W-1:0]   w_fwd;
  logic [W-1:0]   w_lookup;
  logic [15:0]    r_beat_cnt;

`ifdef SBOX_FWD_EN
  assign w_in_mode = in_mode;
  assign w_fwd     = fwd_lanes(w_lookup_src);
`else
  logic w_unused_in_mode;
  assign w_unused_in_mode = in_mode;
  // Mode is tied low, so the mux below always picks the inverse table.
  assign w_in_mode = 1'b0;
  assign w_fwd     = w_inv;
`endif

  assign w_inv    = inv_lanes(w_lookup_src);
  assign w_lookup = w_lookup_mode ? w_fwd : w_inv;
  assign in_ready = w_in_ready;
  assign beat_cnt = r_beat_cnt;

  if (LATENCY == 1) begin : g_lat1
    logic         r_v;
    logic         r_m;
    logic [W-1:0] r_d;
    logic         w_ld;

    assign w_ld          = !r_v || out_ready;
    assign w_in_ready    = !rst && w_ld;
    assign w_lookup_src  = in_data;
    assign w_lookup_mode = w_in_mode;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
        r_m <= 1'b0;
      end else if (w_ld) begin
        r_v <= in_valid;
        if (in_valid) begin
          r_d <= w_lookup;
          r_m <= w_in_mode;
        end
      end
    end

    assign out_valid = r_v;
    assign out_data  = r_d;
    assign out_mode  = r_m;
  end else begin : g_lat2
    logic         r_v0;
    logic         r_m0;
    logic [W-1:0] r_d0;
    logic         r_v1;
    logic         r_m1;
    logic [W-1:0] r_d1;
    logic         w_ld0;
    logic         w_ld1;

    // Stage 0 may refill in the same cycle stage 1 drains into the output.
    assign w_ld1         = !r_v1 || out_ready;
    assign w_ld0         = !r_v0 || w_ld1;
    assign w_in_ready    = !rst && w_ld0;
    assign w_lookup_src  = r_d0;
    assign w_lookup_mode = r_m0;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v0 <= 1'b0;
        r_d0 <= '0;
        r_m0 <= 1'b0;
        r_v1 <= 1'b0;
        r_d1 <= '0;
        r_m1 <= 1'b0;
      end else begin
        if (w_ld0) begin
          r_v0 <= in_valid;
          if (in_valid) begin
            r_d0 <= in_data;
            r_m0 <= w_in_mode;
          end
        end
        if (w_ld1) begin
          r_v1 <= r_v0;
          if (r_v0) begin
            r_d1 <= w_lookup;
            r_m1 <= r_m0;
          end
        end
      end
    end

    assign out_valid = r_v1;
    assign out_data  = r_d1;
    assign out_mode  = r_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= 16'h0000;
    end else if (in_valid && w_in_ready) begin
      r_beat_cnt <= r_beat_cnt + 16'h0001;
    end
  end

endmodule
